ebi_debug_bridge: RTL and testbench
===================================

Name: ebi_debug_bridge

Overview:
Parametrised external-bus (SMC/EBI) slave bridging the host CPU's async static-memory cycles into the FPGA clock domain. Successor to the single-RAM debug block: configurable width/depth, scratch register bank, latched 32-bit counter, masked W1C interrupt controller and LED control register. Sits directly behind the top-level IOBUFs; the tristate enable is exported, not instantiated.

Parameters:
DATA_WIDTH, 16, host data bus width (>=16)
ADDR_WIDTH, 25, host byte address width
SYNC_STAGES, 2, synchroniser depth on cs_n/rd_n/wr_n/irq_i (>=2)
NUM_REGS, 8, scratch registers (1..16)
RAM_BASE, 'h1000, RAM window start, word address
RAM_AW, 5, log2 RAM depth in words
LED_WIDTH, 5, LED outputs
ID_VALUE, 'hDB61, read-only ID register value

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
addr_i  in  ADDR_WIDTH  host byte address; bit 0 ignored
data_i  in  DATA_WIDTH  host write data (IOBUF O)
data_o  out  DATA_WIDTH  host read data (IOBUF I)
data_oe_o  out  1  high = FPGA drives bus
cs_n_i  in  2  chip selects, active-low; access when either low
rd_n_i  in  1  read strobe, active-low
wr_n_i  in  1  write strobe, active-low
irq_i  in  1  external interrupt request
irq_o  out  1  interrupt to host, active-high level
leds_o  out  LED_WIDTH  LED drive

Behaviour:
- Reset (async assert, sync release): state IDLE, data_o=0, data_oe_o=0, irq_o=0, leds_o=0, counter=0, scratch/status/mask/LED regs=0; RAM contents undefined.
- Word address wa = addr_i[ADDR_WIDTH-1:1]. Map: 0 ID (RO); 1 LED ctrl (RW, low LED_WIDTH bits); 2 counter[15:0] (read latches counter[31:16] into shadow); 3 shadow high (RO); 4 irq_status (W1C); 5 irq_mask (RW); 'h10..'h10+NUM_REGS-1 scratch (RW); RAM_BASE..RAM_BASE+2^RAM_AW-1 RAM. Unmapped: reads 0, writes dropped, status bit1 set.
- Counter: free-running 32 bit, wraps 'hFFFFFFFF->0.
- Start event: synchronised cs active edge (all cs_n high -> any low). addr_i/data_i sampled in DECODE (host holds them stable).
- FSM: IDLE -> DECODE on start. DECODE: sync rd_n low & wr_n high -> read; wr_n low & rd_n high -> write performed this cycle, then RELEASE; both or neither low -> no access, status bit1 set, RELEASE. Read of reg -> DRIVE (data_o loaded in DECODE); read of RAM -> RAM_WAIT (1 cycle) -> DRIVE.
- DRIVE: data_oe_o=1 while sync rd_n low and cs active; on rd_n rise -> RELEASE, oe=0 same cycle.
- RELEASE: wait until all cs_n high (synced) -> IDLE.
- Latency from cs edge at pins: reg read data valid SYNC_STAGES+2 clocks; RAM read SYNC_STAGES+3. Host wait states must cover this.
- Abort: cs deasserts in any state -> IDLE next cycle, oe=0, pending write not performed if still in DECODE-pending (write already committed in DECODE stays).
- IRQ: synced irq_i rising edge sets status bit0; bit1 access error. Write 1 clears; set has priority over clear in the same cycle. irq_o = |(status & mask), registered.
- RAM: sync read 1 cycle, write-first not required (no concurrent ports).

Decomposition:
- Package ebi_debug_pkg: register word offsets, FSM state encoding, status bit indices.
- Sub-module ebi_bridge_ram: single-port sync RAM (DATA_WIDTH x 2^RAM_AW).
- Synchroniser and FSM inline.

Test Plan:
- Read ID: cs_n=2'b10, rd_n low, addr 'h0 -> data_o='hDB61, oe high within SYNC_STAGES+2 clocks, oe low after rd_n rise.
- RAM: write 'hA5A5 to byte addr 2*(RAM_BASE+3), read back -> 'hA5A5 at SYNC_STAGES+3; write last word 2^RAM_AW-1 and read word 0 unchanged.
- Counter latch: hold counter to 'h0001_FFFF on reading offset 2 -> low 'hFFFF, then offset 3 reads 'h0001 even after wrap.
- IRQ: mask='h1, pulse irq_i -> irq_o=1; write 'h1 to offset 4 -> irq_o=0; irq edge same cycle as clear -> bit stays set.
- Error: rd_n and wr_n both low -> no write, status bit1=1; unmapped read returns 0.
- Reset mid-DRIVE: assert reset_i async -> data_oe_o=0 immediately, FSM IDLE, leds_o=0.

Source files
------------

// File: rtl/ebi_debug_pkg.sv
// Shared definitions for the EBI debug bridge: register map, FSM states, status bits.
package ebi_debug_pkg;

  localparam logic [31:0] OFF_ID      = 32'h0;
  localparam logic [31:0] OFF_LED     = 32'h1;
  localparam logic [31:0] OFF_CNT_LO  = 32'h2;
  localparam logic [31:0] OFF_CNT_HI  = 32'h3;
  localparam logic [31:0] OFF_STATUS  = 32'h4;
  localparam logic [31:0] OFF_MASK    = 32'h5;
  localparam logic [31:0] OFF_SCRATCH = 32'h10;

  localparam int ST_BIT_IRQ = 0;
  localparam int ST_BIT_ERR = 1;
  localparam int STATUS_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RAM_WAIT,
    S_DRIVE,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/ebi_bridge_ram.sv
// Single-port synchronous RAM behind the host window; one-cycle read latency.
module ebi_bridge_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Write on strobe, register the addressed word every cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
    rdata_o <= r_mem[addr_i];
  end

endmodule

// File: rtl/ebi_debug_bridge.sv
// Async static-memory host slave: synchronised strobes, small register bank,
// scratch registers, RAM window, latched counter and masked W1C interrupts.
module ebi_debug_bridge
  import ebi_debug_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 25,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 8,
  parameter int RAM_BASE    = 'h1000,
  parameter int RAM_AW      = 5,
  parameter int LED_WIDTH   = 5,
  parameter int ID_VALUE    = 'hDB61
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_oe_o,
  input  logic [1:0]            cs_n_i,
  input  logic                  rd_n_i,
  input  logic                  wr_n_i,
  input  logic                  irq_i,
  output logic                  irq_o,
  output logic [LED_WIDTH-1:0]  leds_o
);

  // Synchroniser bundle layout: {irq, wr_n, rd_n, cs_n[1], cs_n[0]}
  logic [4:0]            r_sync [SYNC_STAGES];
  logic [4:0]            w_sync;
  logic                  w_cs_act, w_rd, w_wr, w_irq, w_start;
  logic                  r_cs_prev, r_irq_prev;
  state_t                r_state, w_next;
  logic [31:0]           r_cnt;
  logic [15:0]           r_shadow;
  logic [LED_WIDTH-1:0]  r_led;
  logic [STATUS_W-1:0]   r_status, r_mask, w_st_set, w_st_clr;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_data, w_rdata, w_ram_q;
  logic [DATA_WIDTH-1:0] r_scr [16];
  logic [31:0]           w_wa32, w_ram_off;
  logic                  w_is_reg, w_is_scr, w_is_ram, w_mapped;
  logic                  w_do_write, w_load_reg, w_load_ram, w_err, w_oe, w_ram_we;
  logic                  w_unused;

  // Multi-flop synchroniser for the asynchronous host strobes and irq input.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'b01111;
    end else begin
      r_sync[0] <= {irq_i, wr_n_i, rd_n_i, cs_n_i};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_cs_act = ~(w_sync[0] & w_sync[1]);
  assign w_rd     = ~w_sync[2];
  assign w_wr     = ~w_sync[3];
  assign w_irq    = w_sync[4];
  assign w_start  = w_cs_act & ~r_cs_prev;

  // Address decode; host holds addr_i stable for the whole access.
  assign w_wa32    = 32'(addr_i[ADDR_WIDTH-1:1]);
  assign w_ram_off = w_wa32 - 32'(RAM_BASE);
  assign w_is_reg  = (w_wa32 <= OFF_MASK);
  assign w_is_scr  = (w_wa32 >= OFF_SCRATCH) && (w_wa32 < OFF_SCRATCH + 32'(NUM_REGS));
  assign w_is_ram  = (w_wa32 >= 32'(RAM_BASE)) && (w_wa32 < 32'(RAM_BASE) + (32'd1 << RAM_AW));
  assign w_mapped  = w_is_reg | w_is_scr | w_is_ram;
  assign w_ram_we  = w_do_write & w_is_ram;
  assign w_unused  = ^{addr_i[0], w_ram_off[31:RAM_AW]};

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_is_scr) begin
      w_rdata = r_scr[w_wa32[3:0]];
    end else begin
      case (w_wa32)
        OFF_ID:     w_rdata = DATA_WIDTH'(ID_VALUE);
        OFF_LED:    w_rdata = DATA_WIDTH'(r_led);
        OFF_CNT_LO: w_rdata = DATA_WIDTH'(r_cnt[15:0]);
        OFF_CNT_HI: w_rdata = DATA_WIDTH'(r_shadow);
        OFF_STATUS: w_rdata = DATA_WIDTH'(r_status);
        OFF_MASK:   w_rdata = DATA_WIDTH'(r_mask);
        default:    w_rdata = '0;
      endcase
    end
  end

  // FSM next state and per-cycle strobes; losing chip select aborts from any state.
  always_comb begin
    w_next     = r_state;
    w_do_write = 1'b0;
    w_load_reg = 1'b0;
    w_load_ram = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_cs_act) begin
          w_next = S_IDLE;
        end else if (w_rd && !w_wr) begin
          w_err = ~w_mapped;
          if (w_is_ram) begin
            w_next = S_RAM_WAIT;
          end else begin
            w_load_reg = 1'b1;
            w_next     = S_DRIVE;
          end
        end else if (w_wr && !w_rd) begin
          w_do_write = 1'b1;
          w_err      = ~w_mapped;
          w_next     = S_RELEASE;
        end else begin
          w_err  = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_RAM_WAIT: begin
        if (!w_cs_act) begin
          w_next = S_IDLE;
        end else begin
          w_load_ram = 1'b1;
          w_next     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (!w_cs_act)  w_next = S_IDLE;
        else if (!w_rd) w_next = S_RELEASE;
      end
      S_RELEASE: if (!w_cs_act) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_oe = (r_state == S_DRIVE) && w_rd && w_cs_act;

  // FSM state and edge-detect history.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_cs_prev  <= 1'b0;
      r_irq_prev <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cs_prev  <= w_cs_act;
      r_irq_prev <= w_irq;
    end
  end

  // Free-running counter; reading the low half latches the high half.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_load_reg && (w_wa32 == OFF_CNT_LO)) r_shadow <= r_cnt[31:16];
    end
  end

  // Host-writable registers: LED, mask and scratch bank.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_led  <= '0;
      r_mask <= '0;
      for (int i = 0; i < 16; i++) r_scr[i] <= '0;
    end else if (w_do_write) begin
      if (w_wa32 == OFF_LED)  r_led  <= data_i[LED_WIDTH-1:0];
      if (w_wa32 == OFF_MASK) r_mask <= data_i[STATUS_W-1:0];
      if (w_is_scr)           r_scr[w_wa32[3:0]] <= data_i;
    end
  end

  assign w_st_set[ST_BIT_IRQ] = w_irq & ~r_irq_prev;
  assign w_st_set[ST_BIT_ERR] = w_err;
  assign w_st_clr = (w_do_write && (w_wa32 == OFF_STATUS)) ? data_i[STATUS_W-1:0] : '0;

  // W1C status with set winning over clear; registered masked interrupt.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_st_clr) | w_st_set;
      r_irq    <= |(r_status & r_mask);
    end
  end

  // Read data register: registers load in DECODE, RAM one cycle later.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)         r_data <= '0;
    else if (w_load_reg) r_data <= w_rdata;
    else if (w_load_ram) r_data <= w_ram_q;
  end

  ebi_bridge_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(RAM_AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_off[RAM_AW-1:0]),
    .wdata_i (data_i),
    .rdata_o (w_ram_q)
  );

  assign data_o    = r_data;
  assign data_oe_o = w_oe;
  assign irq_o     = r_irq;
  assign leds_o    = r_led;

endmodule

// File: tb/tb_ebi_debug_bridge.sv
// Self-checking bench for ebi_debug_bridge: vector table, random traffic against
// an abstract register/RAM model, and hand sequences for irq, counter and reset.
module tb_ebi_debug_bridge;

  localparam int S  = 2;
  localparam int RB = 'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] addr_i;
  logic [15:0] data_i, data_o;
  logic        data_oe_o;
  logic [1:0]  cs_n_i;
  logic        rd_n_i, wr_n_i, irq_i, irq_o;
  logic [4:0]  leds_o;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned tb_cnt;

  ebi_debug_bridge dut (
    .clk_i(clk), .reset_i(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .data_oe_o(data_oe_o), .cs_n_i(cs_n_i), .rd_n_i(rd_n_i), .wr_n_i(wr_n_i),
    .irq_i(irq_i), .irq_o(irq_o), .leds_o(leds_o)
  );

  always #5 clk = ~clk;

  // Reference for the free-running counter: clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= tb_cnt + 1;
  end

  // Abstract model of host-visible data registers
  logic [4:0]  m_led;
  logic [15:0] m_scr [8];
  logic [15:0] m_ram [32];
  bit          m_rv  [32];

  task automatic model_write(input int wa, input logic [15:0] d);
    if (wa == 1) m_led = d[4:0];
    else if (wa >= 16 && wa < 24) m_scr[wa-16] = d;
    else if (wa >= RB && wa < RB + 32) begin m_ram[wa-RB] = d; m_rv[wa-RB] = 1'b1; end
  endtask

  task automatic model_read(input int wa, output logic [15:0] d, output bit valid);
    valid = 1'b1; d = '0;
    if (wa == 0) d = 16'hDB61;
    else if (wa == 1) d = 16'(m_led);
    else if (wa >= 16 && wa < 24) d = m_scr[wa-16];
    else if (wa >= RB && wa < RB + 32) begin d = m_ram[wa-RB]; valid = m_rv[wa-RB]; end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] cs, input int wa, input logic [15:0] wd, input bit both);
    logic [31:0] w;
    w = wa;
    @(negedge clk);
    cs_n_i = cs; addr_i = {w[23:0], 1'b0}; data_i = wd; wr_n_i = 1'b0; rd_n_i = both ? 1'b0 : 1'b1;
    repeat (S + 4) @(negedge clk);
    wr_n_i = 1'b1; rd_n_i = 1'b1; cs_n_i = 2'b11;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic host_read(input logic [1:0] cs, input int wa, output logic [15:0] d,
                           output int lat, output logic oe_after, output int unsigned c0);
    logic [31:0] w;
    bit seen;
    w = wa; seen = 0; lat = -1; d = '0;
    @(negedge clk);
    c0 = tb_cnt;
    cs_n_i = cs; addr_i = {w[23:0], 1'b0}; rd_n_i = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (data_oe_o) begin seen = 1; lat = i; d = data_o; end
    end
    @(negedge clk);
    rd_n_i = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 oe_after = data_oe_o;
    @(negedge clk);
    cs_n_i = 2'b11;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic read_chk(input string nm, input logic [1:0] cs, input int wa,
                          input logic [15:0] exp, input int exp_lat);
    logic [15:0] d; int lat; logic oa; int unsigned c0;
    host_read(cs, wa, d, lat, oa, c0);
    check({nm, "_data"}, 32'(d), 32'(exp));
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_oe_off"}, 32'(oa), 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  cs;
    int          wa;
    logic [15:0] wd;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] d, e;
    int lat;
    logic oa;
    bit valid, seen;
    int unsigned c0, c1;
    logic [31:0] v;

    rst = 1'b1; cs_n_i = 2'b11; rd_n_i = 1'b1; wr_n_i = 1'b1; irq_i = 1'b0;
    addr_i = '0; data_i = '0;
    m_led = '0;
    for (int i = 0; i < 8; i++) m_scr[i] = '0;
    for (int i = 0; i < 32; i++) begin m_ram[i] = '0; m_rv[i] = 1'b0; end

    repeat (3) @(negedge clk);
    check("rst_data_o", 32'(data_o), 0);
    check("rst_oe", 32'(data_oe_o), 0);
    check("rst_irq", 32'(irq_o), 0);
    check("rst_leds", 32'(leds_o), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    tbl.push_back('{1, 2'b10, 1,       16'h003F, 16'h0000, 0});
    tbl.push_back('{0, 2'b01, 1,       16'h0000, 16'h001F, S+2});
    tbl.push_back('{0, 2'b10, 0,       16'h0000, 16'hDB61, S+2});
    tbl.push_back('{1, 2'b00, 16,      16'h1234, 16'h0000, 0});
    tbl.push_back('{1, 2'b10, 23,      16'hBEEF, 16'h0000, 0});
    tbl.push_back('{0, 2'b01, 16,      16'h0000, 16'h1234, S+2});
    tbl.push_back('{0, 2'b10, 23,      16'h0000, 16'hBEEF, S+2});
    tbl.push_back('{0, 2'b10, 24,      16'h0000, 16'h0000, S+2});
    tbl.push_back('{0, 2'b10, 6,       16'h0000, 16'h0000, S+2});
    tbl.push_back('{1, 2'b10, RB,      16'h1111, 16'h0000, 0});
    tbl.push_back('{1, 2'b10, RB+3,    16'hA5A5, 16'h0000, 0});
    tbl.push_back('{1, 2'b10, RB+31,   16'h5A5A, 16'h0000, 0});
    tbl.push_back('{0, 2'b10, RB+3,    16'h0000, 16'hA5A5, S+3});
    tbl.push_back('{0, 2'b01, RB+31,   16'h0000, 16'h5A5A, S+3});
    tbl.push_back('{0, 2'b10, RB,      16'h0000, 16'h1111, S+3});
    tbl.push_back('{1, 2'b10, 5,       16'hFFFF, 16'h0000, 0});
    tbl.push_back('{0, 2'b10, 5,       16'h0000, 16'h0003, S+2});
    tbl.push_back('{1, 2'b10, 5,       16'h0000, 16'h0000, 0});
    tbl.push_back('{0, 2'b10, 5,       16'h0000, 16'h0000, S+2});
    tbl.push_back('{1, 2'b10, 0,       16'h1234, 16'h0000, 0});
    tbl.push_back('{0, 2'b10, 0,       16'h0000, 16'hDB61, S+2});

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        host_write(tbl[i].cs, tbl[i].wa, tbl[i].wd, 1'b0);
        model_write(tbl[i].wa, tbl[i].wd);
      end else begin
        read_chk($sformatf("vec%0d", i), tbl[i].cs, tbl[i].wa, tbl[i].exp, tbl[i].lat);
      end
    end
    check("leds_pins", 32'(leds_o), 32'h1F);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      int k, wa;
      logic [1:0] cs;
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: cs = 2'b10;
        1: cs = 2'b01;
        default: cs = 2'b00;
      endcase
      if (k == 0) wa = 1;
      else if (k <= 3) wa = 16 + $urandom_range(0, 7);
      else if (k <= 7) wa = RB + $urandom_range(0, 31);
      else if (k == 8) wa = 24 + $urandom_range(0, 15);
      else wa = 0;
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        host_write(cs, wa, d, 1'b0);
        model_write(wa, d);
      end else begin
        host_read(cs, wa, d, lat, oa, c0);
        model_read(wa, e, valid);
        if (valid) check($sformatf("rnd%0d_wa%0h", n, wa), 32'(d), 32'(e));
        check($sformatf("rnd%0d_lat", n), lat, (wa >= RB) ? S+3 : S+2);
        check($sformatf("rnd%0d_oe_off", n), 32'(oa), 0);
      end
    end

    // Interrupts: edge set, W1C clear, set beats clear in the same cycle
    host_write(2'b10, 4, 16'h0003, 1'b0);
    host_write(2'b10, 5, 16'h0001, 1'b0);
    check("irq_idle", 32'(irq_o), 0);
    @(negedge clk); irq_i = 1'b1;
    repeat (S + 3) @(negedge clk);
    check("irq_set", 32'(irq_o), 1);
    irq_i = 1'b0;
    read_chk("status_irq", 2'b10, 4, 16'h0001, S+2);
    host_write(2'b10, 4, 16'h0001, 1'b0);
    check("irq_cleared", 32'(irq_o), 0);
    @(negedge clk);
    cs_n_i = 2'b10; addr_i = 25'h8; data_i = 16'h0001; wr_n_i = 1'b0;
    @(negedge clk); irq_i = 1'b1;
    repeat (S + 3) @(negedge clk);
    wr_n_i = 1'b1; cs_n_i = 2'b11; irq_i = 1'b0;
    repeat (S + 3) @(negedge clk);
    read_chk("status_set_wins", 2'b10, 4, 16'h0001, S+2);
    check("irq_set_wins", 32'(irq_o), 1);
    host_write(2'b10, 4, 16'h0001, 1'b0);

    // Access errors
    host_write(2'b10, 16, 16'hDEAD, 1'b1);
    read_chk("both_low_nowrite", 2'b10, 16, m_scr[0], S+2);
    read_chk("status_err", 2'b10, 4, 16'h0002, S+2);
    check("irq_err_masked", 32'(irq_o), 0);
    host_write(2'b10, 5, 16'h0003, 1'b0);
    check("irq_err_unmasked", 32'(irq_o), 1);
    host_write(2'b10, 4, 16'h0002, 1'b0);
    read_chk("unmapped_rd", 2'b01, 'h30, 16'h0000, S+2);
    read_chk("status_unmapped", 2'b10, 4, 16'h0002, S+2);
    host_write(2'b10, 4, 16'h0003, 1'b0);
    host_write(2'b10, 5, 16'h0000, 1'b0);

    // Counter latch across the 16-bit boundary
    while (tb_cnt < 32'hFFE0) @(negedge clk);
    host_read(2'b10, 2, d, lat, oa, c0);
    v = c0 + S + 1;
    check("cnt_lo", 32'(d), 32'(v[15:0]));
    check("cnt_lo_lat", lat, S+2);
    read_chk("cnt_hi", 2'b10, 3, v[31:16], S+2);
    while (tb_cnt < 32'h10040) @(negedge clk);
    read_chk("cnt_hi_held", 2'b10, 3, v[31:16], S+2);
    host_read(2'b01, 2, d, lat, oa, c1);
    v = c1 + S + 1;
    check("cnt_lo2", 32'(d), 32'(v[15:0]));
    read_chk("cnt_hi2", 2'b10, 3, v[31:16], S+2);

    // Asynchronous reset in the middle of a read
    host_write(2'b10, 1, 16'h0015, 1'b0);
    check("leds_15", 32'(leds_o), 32'h15);
    host_write(2'b10, 5, 16'h0001, 1'b0);
    @(negedge clk); irq_i = 1'b1;
    repeat (S + 3) @(negedge clk);
    irq_i = 1'b0;
    check("irq_pre_rst", 32'(irq_o), 1);
    @(negedge clk);
    cs_n_i = 2'b10; addr_i = '0; rd_n_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (data_oe_o) seen = 1;
    end
    check("rst_drive_reached", 32'(seen), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'(data_oe_o), 0);
    check("rst_mid_leds", 32'(leds_o), 0);
    check("rst_mid_irq", 32'(irq_o), 0);
    check("rst_mid_data", 32'(data_o), 0);
    @(negedge clk); cs_n_i = 2'b11; rd_n_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (S + 2) @(negedge clk);
    read_chk("post_rst_id", 2'b10, 0, 16'hDB61, S+2);
    read_chk("post_rst_led", 2'b10, 1, 16'h0000, S+2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
